instr_fetch_unit: RTL and testbench

Instruction fetch front-end that sits between the program counter register and decode. It issues the current PC to instruction memory over a request/grant/response interface and tracks in-order outstanding requests. Returned instructions are buffered with their PCs in a small queue and presented to decode via valid/ready. Its `stall_o` drives the program counter register's stall input, so the PC advances only when a fetch request has actually been accepted.

---
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Instruction-memory request/response and decode handshake bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [DATA_W-1:0] imem_rdata_i;
  logic              if_valid_o;
  logic [DATA_W-1:0] if_instr_o;
  logic [ADDR_W-1:0] if_pc_o;
  logic              if_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Credit-limited in-order instruction fetch with a PC/instr queue.
//            Optional macro FETCH_BYPASS_EN: response-to-decode bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [ADDR_W-1:0] pc_i,
  output logic                   stall_o,
  input  wire logic              flush_i,
  instr_fetch_unit_if.master     bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W+1)'(DEPTH);

  logic [CNT_W-1:0]  r_q_cnt;
  logic [CNT_W-1:0]  r_outst;
  logic [CNT_W-1:0]  r_discard;
  logic [PTR_W-1:0]  r_q_wr;
  logic [PTR_W-1:0]  r_q_rd;
  logic [PTR_W-1:0]  r_f_wr;
  logic [PTR_W-1:0]  r_f_rd;
  logic [ADDR_W-1:0] r_q_pc    [DEPTH];
  logic [DATA_W-1:0] r_q_instr [DEPTH];
  logic [ADDR_W-1:0] r_f_pc    [DEPTH];

  logic [CNT_W:0] w_used;
  logic [CNT_W:0] w_budget;
  logic           w_req;
  logic           w_grant;
  logic           w_rsp_drop;
  logic           w_rsp_take;
  logic           w_q_empty;
  logic           w_byp;
  logic           w_valid;
  logic           w_pop;
  logic           w_push;

  // Stale responses still owed by memory also consume credits, so the total
  // number of requests memory can have in flight never exceeds DEPTH.
  assign w_used   = {1'b0, r_q_cnt} + {1'b0, r_outst};
  assign w_budget = w_used + {1'b0, r_discard};
  assign w_req    = ~rst & ~flush_i & (w_used < C_DEPTH) & (w_budget < C_DEPTH);
  assign w_grant  = w_req & bus.imem_gnt_i;

  assign w_rsp_drop = bus.imem_rvalid_i & (r_discard != '0);
  assign w_rsp_take = bus.imem_rvalid_i & (r_discard == '0) & (r_outst != '0);
  assign w_q_empty  = (r_q_cnt == '0);

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_rsp_take & w_q_empty & ~flush_i;
  assign bus.if_instr_o = w_byp ? bus.imem_rdata_i : r_q_instr[r_q_rd];
  assign bus.if_pc_o    = w_byp ? r_f_pc[r_f_rd]   : r_q_pc[r_q_rd];
`else
  assign w_byp = 1'b0;
  assign bus.if_instr_o = r_q_instr[r_q_rd];
  assign bus.if_pc_o    = r_q_pc[r_q_rd];
`endif

  assign w_valid = (~w_q_empty | w_byp) & ~flush_i;
  assign w_pop   = ~w_q_empty & ~flush_i & bus.if_ready_i;
  assign w_push  = w_rsp_take & ~(w_byp & bus.if_ready_i);

  assign bus.imem_req_o  = w_req;
  assign bus.imem_addr_o = pc_i;
  assign bus.if_valid_o  = w_valid;
  assign stall_o         = ~w_grant & ~flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_cnt   <= '0;
      r_outst   <= '0;
      r_discard <= '0;
      r_q_wr    <= '0;
      r_q_rd    <= '0;
      r_f_wr    <= '0;
      r_f_rd    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
        r_f_pc[i]    <= '0;
      end
    end else if (flush_i) begin
      // A response landing in the flush cycle is one of the owed ones.
      r_discard <= r_discard + r_outst - CNT_W'(w_rsp_drop | w_rsp_take);
      r_outst   <= '0;
      r_q_cnt   <= '0;
      r_q_wr    <= '0;
      r_q_rd    <= '0;
      r_f_wr    <= '0;
      r_f_rd    <= '0;
    end else begin
      if (w_grant) begin
        r_f_pc[r_f_wr] <= pc_i;
        r_f_wr         <= r_f_wr + 1'b1;
      end
      if (w_rsp_take) begin
        r_f_rd <= r_f_rd + 1'b1;
      end
      r_outst <= r_outst + CNT_W'(w_grant) - CNT_W'(w_rsp_take);
      if (w_rsp_drop) begin
        r_discard <= r_discard - 1'b1;
      end
      if (w_push) begin
        r_q_pc[r_q_wr]    <= r_f_pc[r_f_rd];
        r_q_instr[r_q_wr] <= bus.imem_rdata_i;
        r_q_wr            <= r_q_wr + 1'b1;
      end
      if (w_pop) begin
        r_q_rd <= r_q_rd + 1'b1;
      end
      r_q_cnt <= r_q_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifndef SYNTHESIS
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rvalid_i && (r_outst == '0) && (r_discard == '0)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Vector table, directed corner cases and randomized model check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_i    (pc_i),
    .stall_o (stall_o),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic rdy, input logic fl);
    pc_i              = pc;
    bus.imem_gnt_i    = gnt;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rd;
    bus.if_ready_i    = rdy;
    flush_i           = fl;
  endtask

  task automatic do_reset();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        rdy, fl;
    logic        e_req, e_stall, e_val, e_valb;
    logic [31:0] e_instr, e_pc;
  } vec_t;

  vec_t tbl [20];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_fq [$];
  logic [31:0] m_if [$];
  int          m_disc;

  initial begin
    drive(32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'b0, bus.imem_req_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o},        32'd1);
    chk("rst_valid", {31'b0, bus.if_valid_o}, 32'd0);
    chk("rst_instr", bus.if_instr_o,          32'd0);
    chk("rst_pc",    bus.if_pc_o,             32'd0);
    @(posedge clk); #1 rst = 1'b0; bus.imem_gnt_i = 1'b0;
    @(negedge clk);
    chk("rel_req",  {31'b0, bus.imem_req_o}, 32'd1);
    chk("rel_addr", bus.imem_addr_o,         32'hDEADBEEF);

    // pc, gnt, rv, rdata, rdy, fl, req, stall, val, val_bypass, instr, pc
    tbl[0]  = '{32'h4,   1,0,32'h0,       0,0, 1,0,0,0, 32'h0,       32'h0};
    tbl[1]  = '{32'h8,   0,1,32'h00500093,0,0, 1,1,0,1, 32'h00500093,32'h4};
    tbl[2]  = '{32'h8,   0,0,32'h0,       1,0, 1,1,1,1, 32'h00500093,32'h4};
    tbl[3]  = '{32'h8,   0,0,32'h0,       0,0, 1,1,0,0, 32'h0,       32'h0};
    tbl[4]  = '{32'h8,   0,0,32'h0,       0,0, 1,1,0,0, 32'h0,       32'h0};
    tbl[5]  = '{32'h0,   1,0,32'h0,       0,0, 1,0,0,0, 32'h0,       32'h0};
    tbl[6]  = '{32'h4,   1,1,32'hAAAA0000,0,0, 1,0,0,1, 32'hAAAA0000,32'h0};
    tbl[7]  = '{32'h8,   1,1,32'hBBBB0004,0,0, 0,1,1,1, 32'hAAAA0000,32'h0};
    tbl[8]  = '{32'h8,   1,0,32'h0,       0,0, 0,1,1,1, 32'hAAAA0000,32'h0};
    tbl[9]  = '{32'h8,   1,0,32'h0,       1,0, 0,1,1,1, 32'hAAAA0000,32'h0};
    tbl[10] = '{32'h8,   1,0,32'h0,       0,0, 1,0,1,1, 32'hBBBB0004,32'h4};
    tbl[11] = '{32'hC,   1,0,32'h0,       1,0, 0,1,1,1, 32'hBBBB0004,32'h4};
    tbl[12] = '{32'hC,   1,0,32'h0,       0,0, 1,0,0,0, 32'h0,       32'h0};
    tbl[13] = '{32'h100, 1,0,32'h0,       0,1, 0,0,0,0, 32'h0,       32'h0};
    tbl[14] = '{32'h100, 0,1,32'h11111111,1,0, 0,1,0,0, 32'h0,       32'h0};
    tbl[15] = '{32'h100, 0,1,32'h22222222,1,0, 1,1,0,0, 32'h0,       32'h0};
    tbl[16] = '{32'h100, 1,0,32'h0,       0,0, 1,0,0,0, 32'h0,       32'h0};
    tbl[17] = '{32'h104, 0,1,32'h33333333,0,0, 1,1,0,1, 32'h33333333,32'h100};
    tbl[18] = '{32'h104, 0,0,32'h0,       1,0, 1,1,1,1, 32'h33333333,32'h100};
    tbl[19] = '{32'h104, 0,0,32'h0,       0,0, 1,1,0,0, 32'h0,       32'h0};

    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic ev;
      ev = BYP ? tbl[i].e_valb : tbl[i].e_val;
      @(posedge clk); #1;
      drive(tbl[i].pc, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i),   {31'b0, bus.imem_req_o}, {31'b0, tbl[i].e_req});
      chk($sformatf("tbl%0d_stall", i), {31'b0, stall_o},        {31'b0, tbl[i].e_stall});
      chk($sformatf("tbl%0d_addr", i),  bus.imem_addr_o,         tbl[i].pc);
      chk($sformatf("tbl%0d_valid", i), {31'b0, bus.if_valid_o}, {31'b0, ev});
      if (ev) begin
        chk($sformatf("tbl%0d_instr", i), bus.if_instr_o, tbl[i].e_instr);
        chk($sformatf("tbl%0d_pc", i),    bus.if_pc_o,    tbl[i].e_pc);
      end
    end

    // Response into an empty queue with decode ready.
    @(posedge clk); #1 drive(32'h200, 1, 0, 32'h0, 1, 0);
    @(negedge clk); chk("byp_grant_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1 drive(32'h204, 0, 1, 32'h00A00113, 1, 0);
    @(negedge clk);
    chk("byp_m_valid", {31'b0, bus.if_valid_o}, {31'b0, BYP});
    if (BYP) begin
      chk("byp_m_instr", bus.if_instr_o, 32'h00A00113);
      chk("byp_m_pc",    bus.if_pc_o,    32'h200);
    end
    @(posedge clk); #1 drive(32'h204, 0, 0, 32'h0, 1, 0);
    @(negedge clk);
    chk("byp_m1_valid", {31'b0, bus.if_valid_o}, {31'b0, ~BYP});
    if (!BYP) chk("byp_m1_instr", bus.if_instr_o, 32'h00A00113);
    @(posedge clk); #1 drive(32'h204, 0, 0, 32'h0, 0, 0);
    @(negedge clk); chk("byp_m2_valid", {31'b0, bus.if_valid_o}, 32'd0);

    // Asynchronous reset with a queued entry.
    @(posedge clk); #1 drive(32'h300, 1, 0, 32'h0, 0, 0);
    @(posedge clk); #1 drive(32'h304, 0, 1, 32'h12345678, 0, 0);
    @(posedge clk); #1 drive(32'h304, 0, 0, 32'h0, 0, 0);
    #1 chk("arst_pre_valid", {31'b0, bus.if_valid_o}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, bus.if_valid_o}, 32'd0);
    chk("arst_req",   {31'b0, bus.imem_req_o}, 32'd0);
    chk("arst_stall", {31'b0, stall_o},        32'd1);
    chk("arst_instr", bus.if_instr_o,          32'd0);
    chk("arst_pc",    bus.if_pc_o,             32'd0);

    // Randomized traffic against a queue-level reference model.
    do_reset();
    m_fq.delete(); m_if.delete(); m_disc = 0;
    begin
      logic [31:0] m_pc;
      m_pc = 32'h1000;
      for (int c = 0; c < 3000; c++) begin
        logic fl, gnt, rv, rdy, e_req, e_stall, byp, e_val, cons;
        logic [31:0] rd;
        ent_t e_ent;
        int used;
        fl  = ($urandom_range(0, 19) == 0);
        gnt = ($urandom_range(0, 2) != 0);
        rv  = ((m_if.size() + m_disc) > 0) && ($urandom_range(0, 1) == 1);
        rdy = ($urandom_range(0, 2) != 0);
        rd  = $urandom;
        @(posedge clk); #1 drive(m_pc, gnt, rv, rd, rdy, fl);
        used    = m_fq.size() + m_if.size();
        e_req   = !fl && (used < DEPTH) && (used + m_disc < DEPTH);
        e_stall = !(e_req && gnt) && !fl;
        byp     = BYP && !fl && (m_fq.size() == 0) && (m_disc == 0) && rv;
        e_val   = !fl && ((m_fq.size() != 0) || byp);
        e_ent   = (m_fq.size() != 0) ? m_fq[0] : ent_t'({byp ? m_if[0] : 32'h0, rd});
        @(negedge clk);
        chk("rnd_req",   {31'b0, bus.imem_req_o}, {31'b0, e_req});
        chk("rnd_stall", {31'b0, stall_o},        {31'b0, e_stall});
        chk("rnd_addr",  bus.imem_addr_o,         m_pc);
        chk("rnd_valid", {31'b0, bus.if_valid_o}, {31'b0, e_val});
        if (e_val) begin
          chk("rnd_instr", bus.if_instr_o, e_ent.instr);
          chk("rnd_pc",    bus.if_pc_o,    e_ent.pc);
        end
        cons = 1'b0;
        if (e_val && rdy) begin
          if (m_fq.size() != 0) void'(m_fq.pop_front());
          else cons = 1'b1;
        end
        if (rv) begin
          if (m_disc > 0) m_disc--;
          else begin
            logic [31:0] p;
            p = m_if.pop_front();
            if (!cons) m_fq.push_back(ent_t'({p, rd}));
          end
        end
        if (e_req && gnt) m_if.push_back(m_pc);
        if (fl) begin
          m_disc += m_if.size();
          m_if.delete();
          m_fq.delete();
          m_pc = {$urandom_range(0, 32'hFFFF), 2'b00};
        end else if (!e_stall) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
